aes_key_schedule_ctrl: RTL and testbench

Sequencing controller for the AES-128 round-key expander. It loads the cipher key and drives the expander through its two-phase protocol for rounds 1..10. During phase 0 it borrows the shared S-box through a request/grant handshake to substitute RotWord(W3). It captures each new round key and serves all 11 round keys to the cipher datapath.

---
 rtl/aes_key_schedule_ctrl.sv | 141 ++++++++++++++
 tb/tb_aes_key_schedule_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule_ctrl.sv
// rtl/aes_key_schedule_ctrl.sv - AES-128 round-key expander sequencing controller
// Optional feature macro: AES_KEY_SCHED_STORE_EN (11-entry round-key buffer with indexed read)
module aes_key_schedule_ctrl #(
  parameter int SBOX_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         sbox_req,
  input  logic         sbox_gnt,
  output logic [127:0] sbox_data_out,
  input  logic [127:0] sbox_data_in,
  output logic         exp_phase,
  output logic [127:0] exp_prev_key,
  output logic [3:0]   exp_round_num,
  output logic [127:0] exp_sbox_data,
  input  logic [127:0] exp_new_key,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SUB_REQ  = 3'd1;
  localparam logic [2:0] ST_SUB_WAIT = 3'd2;
  localparam logic [2:0] ST_EXPAND   = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  localparam logic [3:0] LAST_ROUND = 4'd10;
  localparam logic [1:0] LAT_INIT   = 2'(SBOX_LAT);

  logic [2:0]   state;
  logic [2:0]   state_nxt;
  logic [3:0]   round;
  logic [127:0] cur_key;
  logic [31:0]  sub_word;
  logic [1:0]   lat_cnt;
  logic [31:0]  rot_word;
  logic         load_key;
  logic         unused_bits;

  // A new expansion is only accepted from IDLE; start elsewhere is dropped.
  assign load_key = (state == ST_IDLE) && start;

  // RotWord of the last word of the current key, presented to the shared S-box.
  assign rot_word = {cur_key[23:0], cur_key[31:24]};

  // Next-state selection for the per-round request / wait / expand sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start) state_nxt = ST_SUB_REQ;
      ST_SUB_REQ:  if (sbox_gnt) state_nxt = ST_SUB_WAIT;
      ST_SUB_WAIT: if (lat_cnt == 2'd1) state_nxt = ST_EXPAND;
      ST_EXPAND:   state_nxt = (round == LAST_ROUND) ? ST_DONE : ST_SUB_REQ;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // State register; async reset also drops sbox_req immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Round counter, working key, S-box latency counter and substituted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round    <= 4'd0;
      cur_key  <= '0;
      sub_word <= '0;
      lat_cnt  <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cur_key <= key_in;
            round   <= 4'd1;
          end
        end
        ST_SUB_REQ: begin
          if (sbox_gnt) lat_cnt <= LAT_INIT;
        end
        ST_SUB_WAIT: begin
          lat_cnt <= lat_cnt - 2'd1;
          // The S-box result is valid in the last wait cycle.
          if (lat_cnt == 2'd1) sub_word <= sbox_data_in[31:0];
        end
        ST_EXPAND: begin
          cur_key <= exp_new_key;
          if (round != LAST_ROUND) round <= round + 4'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);
  assign sbox_req      = (state == ST_SUB_REQ);
  assign sbox_data_out = sbox_req ? {96'b0, rot_word} : '0;
  assign exp_phase     = (state == ST_EXPAND);
  assign exp_prev_key  = cur_key;
  assign exp_round_num = busy ? round : 4'd0;
  assign exp_sbox_data = {96'b0, sub_word};

`ifdef AES_KEY_SCHED_STORE_EN
  logic [127:0] rk [0:10];

  // Round-key buffer: slot 0 takes the cipher key, slot N the key from round N.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) rk[i] <= '0;
    end else if (load_key) begin
      rk[0] <= key_in;
    end else if (state == ST_EXPAND) begin
      rk[round] <= exp_new_key;
    end
  end

  // Combinational read; indices past the last round read as zero.
  always_comb begin
    rk_out = '0;
    if (rk_idx <= LAST_ROUND) rk_out = rk[rk_idx];
  end

  assign unused_bits = ^sbox_data_in[127:32];
`else
  // Without the buffer only the most recent key is visible.
  assign rk_out      = cur_key;
  assign unused_bits = ^{sbox_data_in[127:32], rk_idx};
`endif

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// tb/tb_aes_key_schedule_ctrl.sv - self-checking bench for aes_key_schedule_ctrl (SBOX_LAT 1 and 2)
module tb_aes_key_schedule_ctrl;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_K1  = {4{32'h62636363}};
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [95:0]  JUNK     = 96'hc3a55a3c0ff09669e11e7bd4;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic [3:0]   rk_idx = 4'd0;
  logic         gnt [2];
  logic         busy [2];
  logic         done [2];
  logic         sbox_req [2];
  logic         exp_phase [2];
  logic [3:0]   exp_round_num [2];
  logic [127:0] sbox_data_out [2];
  logic [127:0] sbox_data_in [2];
  logic [127:0] exp_prev_key [2];
  logic [127:0] exp_sbox_data [2];
  logic [127:0] exp_new_key [2];
  logic [127:0] rk_out [2];
  logic [31:0]  sb_s1 [2];
  logic [31:0]  sb_s2 [2];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int start_cyc = 0;
  int exp_lat [2] = '{-1, -1};
  bit tmo = 1'b0;
  bit lit_en = 1'b0;
  logic [127:0] lit_exp = '0;

  // Model state
  bit           m_act [2];
  int           m_round [2];
  int           m_req_t [2];
  int           m_exp_t [2];
  int           m_done_t [2];
  logic [127:0] m_key [2];
  logic [127:0] m_cur [2];
  logic [127:0] m_rk [2][11];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [2047:0] t;
    t = SBOX;
    return t[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  function automatic logic [31:0] rotw(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Reference key expansion over the 44-word schedule.
  function automatic logic [127:0] gold_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = subw(rotw(t)) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // External expander: phase-1 combination of previous key, substituted word and Rcon.
  function automatic logic [127:0] expander(input logic [127:0] prev, input logic [31:0] sw,
                                            input logic [3:0] rn);
    logic [7:0]  rc;
    logic [31:0] t, w4, w5, w6, w7;
    case (rn)
      4'd1: rc = 8'h01;  4'd2: rc = 8'h02;  4'd3: rc = 8'h04;  4'd4: rc = 8'h08;
      4'd5: rc = 8'h10;  4'd6: rc = 8'h20;  4'd7: rc = 8'h40;  4'd8: rc = 8'h80;
      4'd9: rc = 8'h1b;  4'd10: rc = 8'h36; default: rc = 8'h00;
    endcase
    t  = sw ^ {rc, 24'h0};
    w4 = prev[127:96] ^ t;
    w5 = prev[95:64] ^ w4;
    w6 = prev[63:32] ^ w5;
    w7 = prev[31:0] ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  aes_key_schedule_ctrl #(.SBOX_LAT(1)) u_dut_lat1 (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy[0]), .done(done[0]),
    .sbox_req(sbox_req[0]), .sbox_gnt(gnt[0]), .sbox_data_out(sbox_data_out[0]),
    .sbox_data_in(sbox_data_in[0]), .exp_phase(exp_phase[0]), .exp_prev_key(exp_prev_key[0]),
    .exp_round_num(exp_round_num[0]), .exp_sbox_data(exp_sbox_data[0]),
    .exp_new_key(exp_new_key[0]), .rk_idx(rk_idx), .rk_out(rk_out[0]));

  aes_key_schedule_ctrl #(.SBOX_LAT(2)) u_dut_lat2 (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy[1]), .done(done[1]),
    .sbox_req(sbox_req[1]), .sbox_gnt(gnt[1]), .sbox_data_out(sbox_data_out[1]),
    .sbox_data_in(sbox_data_in[1]), .exp_phase(exp_phase[1]), .exp_prev_key(exp_prev_key[1]),
    .exp_round_num(exp_round_num[1]), .exp_sbox_data(exp_sbox_data[1]),
    .exp_new_key(exp_new_key[1]), .rk_idx(rk_idx), .rk_out(rk_out[1]));

  // Shared S-box stand-in: result appears SBOX_LAT cycles after an accepted grant.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (sbox_req[d] && gnt[d]) sb_s1[d] <= subw(sbox_data_out[d][31:0]);
      sb_s2[d] <= sb_s1[d];
    end
  end
  assign sbox_data_in[0] = {JUNK, sb_s1[0]};
  assign sbox_data_in[1] = {JUNK, sb_s2[1]};

  always_comb begin
    for (int d = 0; d < 2; d++)
      exp_new_key[d] = expander(exp_prev_key[d], exp_sbox_data[d][31:0], exp_round_num[d]);
  end

  task automatic chk(input string name, input int d, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", name, d, cyc, act, exp);
  endtask

  // Compare process: model timeline per DUT, checked every cycle.
  always @(negedge clk) begin
    bit in_req, in_exp, in_done;
    logic [127:0] prev_k, want_rk;
    for (int d = 0; d < 2; d++) begin
      if (tmo && d == 0) chk("run_timeout", d, 128'(tmo), 128'd0);
      if (rst) begin
        m_act[d] = 1'b0; m_round[d] = 0; m_cur[d] = '0; m_done_t[d] = -1; m_exp_t[d] = -1;
        for (int i = 0; i < 11; i++) m_rk[d][i] = '0;
        chk("rst_busy", d, 128'(busy[d]), 128'd0);
        chk("rst_done", d, 128'(done[d]), 128'd0);
        chk("rst_sbox_req", d, 128'(sbox_req[d]), 128'd0);
        chk("rst_exp_phase", d, 128'(exp_phase[d]), 128'd0);
        chk("rst_round_num", d, 128'(exp_round_num[d]), 128'd0);
        chk("rst_sbox_data_out", d, sbox_data_out[d], 128'd0);
        chk("rst_prev_key", d, exp_prev_key[d], 128'd0);
        chk("rst_exp_sbox_data", d, exp_sbox_data[d], 128'd0);
        chk("rst_rk_out", d, rk_out[d], 128'd0);
      end else begin
        in_req  = m_act[d] && m_exp_t[d] < 0 && cyc >= m_req_t[d];
        in_exp  = m_act[d] && cyc == m_exp_t[d];
        in_done = m_act[d] && cyc == m_done_t[d];
        prev_k  = (m_act[d] && m_round[d] >= 1) ? gold_key(m_key[d], m_round[d] - 1) : '0;
        chk("busy", d, 128'(busy[d]), 128'(m_act[d]));
        chk("done", d, 128'(done[d]), 128'(in_done));
        chk("sbox_req", d, 128'(sbox_req[d]), 128'(in_req));
        chk("exp_phase", d, 128'(exp_phase[d]), 128'(in_exp));
        chk("round_num", d, 128'(exp_round_num[d]), m_act[d] ? 128'(m_round[d]) : 128'd0);
        chk("sbox_data_out", d, sbox_data_out[d],
            in_req ? {96'h0, rotw(prev_k[31:0])} : 128'd0);
        chk("prev_key", d, exp_prev_key[d], m_cur[d]);
        if (in_exp)
          chk("exp_sbox_data", d, exp_sbox_data[d], {96'h0, subw(rotw(prev_k[31:0]))});
`ifdef AES_KEY_SCHED_STORE_EN
        want_rk = (rk_idx <= 4'd10) ? m_rk[d][rk_idx] : '0;
`else
        want_rk = m_cur[d];
`endif
        chk("rk_out_model", d, rk_out[d], want_rk);
        if (lit_en) chk("rk_out_literal", d, rk_out[d], lit_exp);
        if (done[d] && exp_lat[d] >= 0)
          chk("done_latency", d, 128'(cyc - start_cyc), 128'(exp_lat[d]));
        // Advance the model.
        if (in_req && gnt[d]) m_exp_t[d] = cyc + (d + 1) + 1;
        if (in_exp) begin
          m_cur[d] = gold_key(m_key[d], m_round[d]);
          m_rk[d][m_round[d]] = m_cur[d];
          if (m_round[d] == 10) m_done_t[d] = cyc + 1;
          else begin
            m_round[d]++; m_req_t[d] = cyc + 1; m_exp_t[d] = -1;
          end
        end
        if (!m_act[d] && start) begin
          m_act[d] = 1'b1; m_key[d] = key_in; m_round[d] = 1; m_req_t[d] = cyc + 1;
          m_exp_t[d] = -1; m_done_t[d] = -1; m_cur[d] = key_in; m_rk[d][0] = key_in;
        end
        if (in_done) m_act[d] = 1'b0;
      end
    end
  end

  task automatic run_key(input logic [127:0] key, input int stall_at, input int restart_at,
                         input int rst_at, input int lat0, input int lat1);
    bit fin;
    exp_lat[0] = lat0;
    exp_lat[1] = lat1;
    @(posedge clk); #1;
    key_in = key; start = 1'b1; start_cyc = cyc;
    fin = 1'b0;
    for (int t = 1; t <= 120 && !fin; t++) begin
      @(posedge clk); #1;
      start  = (t == restart_at);
      key_in = (t == restart_at) ? (key ^ 128'h5a) : ~key;
      gnt[0] = !(stall_at > 0 && t >= stall_at && t < stall_at + 5);
      rst    = (t == rst_at);
      if (t > 2 && !rst && !busy[0] && !busy[1]) fin = 1'b1;
    end
    if (!fin) begin
      tmo = 1'b1; @(posedge clk); #1; tmo = 1'b0;
    end
    gnt[0] = 1'b1; rst = 1'b0; start = 1'b0;
    exp_lat[0] = -1;
    exp_lat[1] = -1;
  endtask

  task automatic readback(input logic [127:0] k1, input logic [127:0] k10, input bit cleared);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      rk_idx = 4'(i);
`ifdef AES_KEY_SCHED_STORE_EN
      lit_en  = cleared || i == 1 || i >= 10;
      lit_exp = (cleared || i > 10) ? 128'd0 : ((i == 1) ? k1 : k10);
`else
      lit_en  = 1'b1;
      lit_exp = cleared ? 128'd0 : k10;
`endif
    end
    @(posedge clk); #1;
    lit_en = 1'b0; rk_idx = 4'd0;
  endtask

  initial begin
    gnt[0] = 1'b1; gnt[1] = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    run_key(FIPS_KEY, -1, -1, -1, 31, 41);
    readback(FIPS_K1, FIPS_K10, 1'b0);
    run_key(FIPS_KEY, 7, -1, -1, 36, 41);
    readback(FIPS_K1, FIPS_K10, 1'b0);
    run_key(128'd0, -1, -1, -1, 31, 41);
    readback(ZERO_K1, ZERO_K10, 1'b0);
    run_key(FIPS_KEY, -1, 10, -1, 31, 41);
    readback(FIPS_K1, FIPS_K10, 1'b0);
    run_key(FIPS_KEY, -1, -1, 15, -1, -1);
    readback(128'd0, 128'd0, 1'b1);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
